// File: rtl/mvu_pe_acc_pkg.sv
// Shared MVAU definitions for the PE accumulator.
// Holds default widths, fold factor, state type and a counter-width helper.
package mvu_pe_acc_pkg;

    // Default adder-tree partial-sum width
    localparam int unsigned MVAU_TDSTI = 4;
    // Default accumulator / output width
    localparam int unsigned MVAU_TDST  = 16;
    // Default synapse fold (partial sums per output)
    localparam int unsigned MVAU_SF    = 8;

    // EMPTY: next accepted beat starts a new fold.
    // ACCUM: a fold is in progress.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    // Fold counter width; a fold of one still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned sf);
        return (sf > 1) ? $clog2(sf) : 1;
    endfunction

endpackage

// File: rtl/mvu_pe_acc.sv
// MVU PE accumulator: sums SF popcount partial sums per dot product and
// presents each result through a single-entry valid/ready output buffer.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_v, in_add        partial-sum stream (in_add is unsigned popcount)
//   in_rdy              partial sum accepted when in_v && in_rdy
//   out_v, out_acc      completed dot-product sum and its valid
//   out_rdy             downstream accepts out_acc
module mvu_pe_acc
    import mvu_pe_acc_pkg::*;
#(
    parameter int unsigned TDstI = MVAU_TDSTI,
    parameter int unsigned TDst  = MVAU_TDST,
    parameter int unsigned SF    = MVAU_SF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_v,
    input  logic [TDstI-1:0] in_add,
    output logic             in_rdy,
    output logic             out_v,
    input  logic             out_rdy,
    output logic [TDst-1:0]  out_acc
);

    localparam int unsigned CW = cnt_width(SF);
    localparam logic [CW-1:0] FCNT_LAST = CW'(SF - 1);

    acc_state_e    r_state;
    acc_state_e    w_state_nxt;
    logic [CW-1:0] r_fcnt;
    logic [TDst-1:0] r_acc;
    logic [TDst-1:0] r_out;
    logic          r_ov;

    logic          w_in_rdy;
    logic          w_accept;
    logic          w_last;
    logic          w_first;
    logic [TDst-1:0] w_add_ext;
    logic [TDst-1:0] w_sum;

    // Single output buffer: free when empty or draining this cycle.
    assign w_in_rdy  = !r_ov || out_rdy;
    assign w_accept  = in_v && w_in_rdy;
    assign w_last    = (r_fcnt == FCNT_LAST);
    assign w_add_ext = TDst'(in_add);

    // First beat of a fold discards whatever acc held before.
    assign w_sum = w_first ? w_add_ext : (r_acc + w_add_ext);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept && (SF > 1)) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept && w_last) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State-derived outputs
    always_comb begin
        w_first = 1'b0;
        unique case (r_state)
            ST_EMPTY: w_first = 1'b1;
            ST_ACCUM: w_first = 1'b0;
            default:  w_first = 1'b1;
        endcase
    end

    // Fold counter and running sum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fcnt <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_fcnt <= w_last ? '0 : (r_fcnt + CW'(1));
            r_acc  <= w_sum;
        end
    end

    // Output buffer: a final beat refills it in the same edge that a
    // transfer drains it, so back-to-back results see no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
            r_ov  <= 1'b0;
        end else if (w_accept && w_last) begin
            r_out <= w_sum;
            r_ov  <= 1'b1;
        end else if (out_rdy) begin
            r_ov  <= 1'b0;
        end
    end

    assign in_rdy  = w_in_rdy;
    assign out_v   = r_ov;
    assign out_acc = r_out;

endmodule

// File: doc/mvu_pe_acc.md
MVU_PE_ACC -- requirements
Module: mvu_pe_acc

Interface
REQ-001 The block SHALL take parameter TDstI, default 4: width of the adder-tree partial sum input.
REQ-002 The block SHALL take parameter TDst, default 16: width of the accumulator and the output, with TDst >= TDstI.
REQ-003 The block SHALL take parameter SF, default 8: synapse fold, the number of partial sums per output, with SF >= 1.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_v  input  1  in_add valid.
REQ-007 in_add  input  TDstI  unsigned partial sum (popcount) from PE adder tree.
REQ-008 in_rdy  output  1  block accepts in_add this cycle.
REQ-009 out_v  output  1  out_acc valid.
REQ-010 out_rdy  input  1  downstream accepts out_acc.
REQ-011 out_acc  output  TDst  completed dot-product sum.

Function
REQ-012 Input handshake: a beat SHALL be accepted iff in_v && in_rdy at a rising edge.
REQ-013 in_rdy SHALL equal !out_v || out_rdy (combinational; single output buffer).
REQ-014 Fold counter fcnt SHALL run 0..SF-1, advance by one per accepted beat, and wrap to 0 after SF-1.
REQ-015 Accepted beat with fcnt==0: acc SHALL load zero-extended in_add, discarding the previous sum.
REQ-016 Accepted beat with 0<fcnt<SF-1: acc SHALL become acc + zero-extended in_add, modulo 2^TDst.
REQ-017 Accepted beat with fcnt==SF-1: out_acc SHALL load the final sum (acc + in_add, or in_add alone when SF==1) and out_v SHALL be set on the next edge. Latency is 1 cycle.
REQ-018 State encoding: EMPTY (fcnt==0) and ACCUM (fcnt>0). EMPTY->ACCUM on an accepted beat when SF>1. ACCUM->EMPTY on the accepted beat at fcnt==SF-1. Otherwise the state holds.
REQ-019 Output handshake: out_v && out_rdy SHALL complete a transfer, and out_v SHALL clear next cycle unless REQ-020 applies.
REQ-020 Simultaneous output transfer and final-beat acceptance: out_acc SHALL take the new sum and out_v SHALL stay 1, with no bubble and no loss.
REQ-021 Back-pressure: while out_v && !out_rdy, in_rdy SHALL be 0, and acc, fcnt and out_acc SHALL hold.
REQ-022 in_add SHALL be ignored when !in_v or !in_rdy.
REQ-023 Overflow SHALL wrap silently modulo 2^TDst, with no saturation and no flag.
REQ-024 out_acc SHALL be stable while out_v && !out_rdy.

Reset
REQ-025 With rst_n==0 at an edge: fcnt=0, acc=0, out_acc=0, out_v=0; state EMPTY.
REQ-026 Reset mid-fold SHALL discard the partial sum and any pending output, and the first beat after reset SHALL be treated as fcnt==0.
REQ-027 in_rdy SHALL be 1 during and immediately after reset.

Structure
REQ-028 TDstI, TDst and SF SHALL be sourced from the shared mvau_defn definitions, and no block-local typedefs are required.
REQ-029 The block SHALL be a single module with no sub-module; the fold counter, accumulator and output buffer are inline.
REQ-030 Counter width SHALL be $clog2(SF), minimum 1 bit.

Verification
REQ-031 TDstI=4, TDst=8, SF=4, out_rdy=1; in_add 3,5,7,9 on consecutive cycles -> out_v=1 with out_acc=24 one cycle after the 4th beat, then out_v=0.
REQ-032 Same config, back-to-back folds 1,1,1,1 then 2,2,2,2, out_rdy=1 -> out_acc=4 then 8 on consecutive output cycles.
REQ-033 Same config, out_rdy=0 after the first result 24 -> in_rdy=0 and out_acc held at 24; release out_rdy while the next fold's last beat is pending -> 24 transfers, then the next sum transfers with no bubble.
REQ-034 TDstI=4, TDst=6, SF=8; eight beats of 15 -> out_acc=56 (120 mod 64).
REQ-035 SF=1; in_add 5, 0, 15 -> out_acc 5, 0, 15, each one cycle after its input.
REQ-036 SF=4; assert rst_n=0 after 2 beats (6, 6), then feed 1,2,3,4 -> out_acc=10, with no output from the aborted fold.
